// File: rtl/input_port_ctrl_if.sv
// input_port_ctrl_if
//   Bundles the flit-in, arbiter and flit-out signals of one crossbar input
//   port so the controller and its environment connect through one port.
//   Optional feature macro: INPUT_PORT_TIMEOUT_EN (adds the drop signal).
// Signals
//   in_valid/in_ready/in_data/in_last    upstream flit handshake
//   arb_addr/arb_busy                    busy-select query of an output
//   claim_req/claim_grant/release_pulse  central lock claim and release
//   out_valid/out_ready/out_data/out_last crossbar flit handshake
//   drop                                 packet discarded pulse (timeout build)
// Modports
//   master  the input port controller
//   slave   the surrounding router fabric (upstream, arbiter, crossbar)
// "release" is a reserved word in SystemVerilog, so the free-output pulse
// is carried as release_pulse.
interface input_port_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_last;
    logic [3:0]        arb_addr;
    logic              arb_busy;
    logic              claim_req;
    logic              claim_grant;
    logic              release_pulse;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
`ifdef INPUT_PORT_TIMEOUT_EN
    logic              drop;
`endif

    modport master (
        input  in_valid, in_data, in_last, arb_busy, claim_grant, out_ready,
`ifdef INPUT_PORT_TIMEOUT_EN
        output drop,
`endif
        output in_ready, arb_addr, claim_req, release_pulse, out_valid,
               out_data, out_last
    );

    modport slave (
        output in_valid, in_data, in_last, arb_busy, claim_grant, out_ready,
`ifdef INPUT_PORT_TIMEOUT_EN
        input  drop,
`endif
        input  in_ready, arb_addr, claim_req, release_pulse, out_valid,
               out_data, out_last
    );
endinterface

// File: rtl/input_port_ctrl.sv
// input_port_ctrl
//   Per-input-port controller of the 16x16 crossbar router. Buffers incoming
//   flits in a small FIFO, takes the destination from the header flit's low
//   nibble, waits for that output to be free, claims it through the central
//   lock, streams the packet out and releases the output after the last flit.
//   Optional feature macro: INPUT_PORT_TIMEOUT_EN -- a packet that cannot win
//   its output within TIMEOUT_CYC request cycles is discarded.
// Parameters
//   DATA_W       flit width; header flit carries the destination in [3:0]
//   DEPTH        FIFO entries, power of 2, >= 2
//   TIMEOUT_CYC  request wait limit (timeout build only), >= 1
// Ports
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   input_port_ctrl_if master modport (flit in, arbiter, flit out)
module input_port_ctrl #(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 8,
    parameter int TIMEOUT_CYC = 256
) (
    input  logic               clk,
    input  logic               rst,
    input_port_ctrl_if.master  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

`ifdef INPUT_PORT_TIMEOUT_EN
    typedef enum logic [2:0] {IDLE, REQ, XFER, REL, DROP} state_t;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    logic [CW-1:0] wait_cnt;
    logic          timeout_hit;
    logic          drop_pulse;
`else
    typedef enum logic [2:0] {IDLE, REQ, XFER, REL} state_t;
`endif

    state_t state, state_nx;

    logic [DATA_W:0]   mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_data;
    logic              head_last;
    logic [3:0]        dest;

    logic              claim;
    logic              rel;
    logic              ovalid;
    logic [3:0]        addr;

    assign empty     = (count == '0);
    assign full      = (count == FULL_CNT);
    assign push      = bus.in_valid && !full;
    assign head_data = mem[rd_ptr][DATA_W-1:0];
    assign head_last = mem[rd_ptr][DATA_W];

    // FIFO storage carries no reset; the head is only observed while the
    // count says it holds a valid entry.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_last, bus.in_data};
        end
    end

    // FIFO pointers and occupancy; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // State register and the destination captured from the header at the
    // IDLE -> REQ step (the header itself stays queued for forwarding).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            dest  <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && !empty) begin
                dest <= head_data[3:0];
            end
        end
    end

`ifdef INPUT_PORT_TIMEOUT_EN
    // Request-wait counter: cleared while idle so it starts at zero on REQ
    // entry, then counts every request cycle that ends without a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (state == IDLE) begin
            wait_cnt <= '0;
        end else if (state == REQ && !(claim && bus.claim_grant)) begin
            wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // The last allowed request cycle is the one where the count still reads
    // TIMEOUT_CYC-1; leaving at that edge gives exactly TIMEOUT_CYC REQ cycles.
    assign timeout_hit = (int'(wait_cnt) == TIMEOUT_CYC - 1);
`endif

    // Next-state and output decode.
    always_comb begin
        state_nx = state;
        addr     = '0;
        claim    = 1'b0;
        rel      = 1'b0;
        ovalid   = 1'b0;
        pop      = 1'b0;
`ifdef INPUT_PORT_TIMEOUT_EN
        drop_pulse = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_nx = REQ;
                end
            end
            REQ: begin
                addr  = dest;
                claim = !bus.arb_busy;
                if (claim && bus.claim_grant) begin
                    state_nx = XFER;
                end
`ifdef INPUT_PORT_TIMEOUT_EN
                else if (timeout_hit) begin
                    state_nx = DROP;
                end
`endif
            end
            XFER: begin
                addr   = dest;
                ovalid = !empty;
                pop    = ovalid && bus.out_ready;
                if (pop && head_last) begin
                    state_nx = REL;
                end
            end
            REL: begin
                addr     = dest;
                rel      = 1'b1;
                state_nx = IDLE;
            end
`ifdef INPUT_PORT_TIMEOUT_EN
            DROP: begin
                pop = !empty;
                if (pop && head_last) begin
                    drop_pulse = 1'b1;
                    state_nx   = IDLE;
                end
            end
`endif
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign bus.in_ready      = !full;
    assign bus.arb_addr      = addr;
    assign bus.claim_req     = claim;
    assign bus.release_pulse = rel;
    assign bus.out_valid     = ovalid;
    assign bus.out_data      = empty ? '0 : head_data;
    assign bus.out_last      = !empty && head_last;
`ifdef INPUT_PORT_TIMEOUT_EN
    assign bus.drop          = drop_pulse;
`endif

endmodule

// File: tb/tb_input_port_ctrl.sv
// tb_input_port_ctrl
//   Directed bench for input_port_ctrl: a per-cycle vector table covering a
//   3-flit packet and back-to-back single-flit packets, followed by
//   hand-written sequences for output-busy waiting, FIFO overflow, reset in
//   mid-transfer and (timeout build) packet dropping.
module tb_input_port_ctrl;

    logic clk;
    logic rst;
    logic grant_en;

    int total;
    int bad;

    input_port_ctrl_if #(.DATA_W(32)) bus ();

    // Lock model: grants any request in the same cycle while enabled.
    assign bus.claim_grant = grant_en & bus.claim_req;

    input_port_ctrl #(
        .DATA_W      (32),
        .DEPTH       (8),
        .TIMEOUT_CYC (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        in_valid;
        logic [31:0] in_data;
        logic        in_last;
        logic        arb_busy;
        logic        gnt;
        logic        out_ready;
        logic        exp_in_ready;
        logic [3:0]  exp_addr;
        logic        exp_claim;
        logic        exp_rel;
        logic        exp_ovalid;
        logic [31:0] exp_odata;
        logic        exp_olast;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(input logic iv, input logic [31:0] id, input logic il,
                                input logic busy, input logic g, input logic ordy,
                                input logic irdy, input logic [3:0] ad, input logic cl,
                                input logic rl, input logic ov, input logic [31:0] od,
                                input logic ol);
        vec_t v;
        v.in_valid     = iv;
        v.in_data      = id;
        v.in_last      = il;
        v.arb_busy     = busy;
        v.gnt          = g;
        v.out_ready    = ordy;
        v.exp_in_ready = irdy;
        v.exp_addr     = ad;
        v.exp_claim    = cl;
        v.exp_rel      = rl;
        v.exp_ovalid   = ov;
        v.exp_odata    = od;
        v.exp_olast    = ol;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] id, input logic il);
        bus.in_valid = iv;
        bus.in_data  = id;
        bus.in_last  = il;
    endtask

    task automatic nextCyc();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        bus.arb_busy  = 1'b0;
        bus.out_ready = 1'b0;
        grant_en      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        drive(v.in_valid, v.in_data, v.in_last);
        bus.arb_busy  = v.arb_busy;
        grant_en      = v.gnt;
        bus.out_ready = v.out_ready;
    endtask

    task automatic checkOutput(input vec_t v, input int idx);
        check($sformatf("vec%0d in_ready", idx), 32'(bus.in_ready), 32'(v.exp_in_ready));
        check($sformatf("vec%0d arb_addr", idx), 32'(bus.arb_addr), 32'(v.exp_addr));
        check($sformatf("vec%0d claim_req", idx), 32'(bus.claim_req), 32'(v.exp_claim));
        check($sformatf("vec%0d release", idx), 32'(bus.release_pulse), 32'(v.exp_rel));
        check($sformatf("vec%0d out_valid", idx), 32'(bus.out_valid), 32'(v.exp_ovalid));
        check($sformatf("vec%0d out_data", idx), bus.out_data, v.exp_odata);
        check($sformatf("vec%0d out_last", idx), 32'(bus.out_last), 32'(v.exp_olast));
    endtask

    task automatic checkResetValues(input string tag);
        check({tag, " in_ready"}, 32'(bus.in_ready), 32'd1);
        check({tag, " arb_addr"}, 32'(bus.arb_addr), 32'd0);
        check({tag, " claim_req"}, 32'(bus.claim_req), 32'd0);
        check({tag, " release"}, 32'(bus.release_pulse), 32'd0);
        check({tag, " out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, " out_data"}, bus.out_data, 32'd0);
        check({tag, " out_last"}, 32'(bus.out_last), 32'd0);
`ifdef INPUT_PORT_TIMEOUT_EN
        check({tag, " drop"}, 32'(bus.drop), 32'd0);
`endif
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        grant_en = 1'b1;
        drive(1'b0, 32'h0, 1'b0);
        bus.arb_busy  = 1'b0;
        bus.out_ready = 1'b0;

        // Vector table: 3-flit packet to port 5, then single-flit packets to 15 and 0.
        //              iv  data          il busy g  rdy | irdy addr cl  rl  ov  odata         ol
        vq.push_back(mk(1, 32'h0000_00A5, 0, 0, 1, 1,   1, 4'd0,  0,  0,  0, 32'h0,         0));
        vq.push_back(mk(1, 32'h0000_00B1, 0, 0, 1, 1,   1, 4'd0,  0,  0,  0, 32'h0000_00A5, 0));
        vq.push_back(mk(1, 32'h0000_00C2, 1, 0, 1, 1,   1, 4'd5,  1,  0,  0, 32'h0000_00A5, 0));
        vq.push_back(mk(0, 32'h0,         0, 0, 1, 1,   1, 4'd5,  0,  0,  1, 32'h0000_00A5, 0));
        vq.push_back(mk(0, 32'h0,         0, 0, 1, 1,   1, 4'd5,  0,  0,  1, 32'h0000_00B1, 0));
        vq.push_back(mk(0, 32'h0,         0, 0, 1, 1,   1, 4'd5,  0,  0,  1, 32'h0000_00C2, 1));
        vq.push_back(mk(0, 32'h0,         0, 0, 1, 1,   1, 4'd5,  0,  1,  0, 32'h0,         0));
        vq.push_back(mk(0, 32'h0,         0, 0, 1, 1,   1, 4'd0,  0,  0,  0, 32'h0,         0));
        vq.push_back(mk(1, 32'h0000_003F, 1, 0, 1, 1,   1, 4'd0,  0,  0,  0, 32'h0,         0));
        vq.push_back(mk(1, 32'h0000_0040, 1, 0, 1, 1,   1, 4'd0,  0,  0,  0, 32'h0000_003F, 1));
        vq.push_back(mk(0, 32'h0,         0, 0, 1, 1,   1, 4'd15, 1,  0,  0, 32'h0000_003F, 1));
        vq.push_back(mk(0, 32'h0,         0, 0, 1, 1,   1, 4'd15, 0,  0,  1, 32'h0000_003F, 1));
        vq.push_back(mk(0, 32'h0,         0, 0, 1, 1,   1, 4'd15, 0,  1,  0, 32'h0000_0040, 1));
        vq.push_back(mk(0, 32'h0,         0, 0, 1, 1,   1, 4'd0,  0,  0,  0, 32'h0000_0040, 1));
        vq.push_back(mk(0, 32'h0,         0, 0, 1, 1,   1, 4'd0,  1,  0,  0, 32'h0000_0040, 1));
        vq.push_back(mk(0, 32'h0,         0, 0, 1, 1,   1, 4'd0,  0,  0,  1, 32'h0000_0040, 1));
        vq.push_back(mk(0, 32'h0,         0, 0, 1, 1,   1, 4'd0,  0,  1,  0, 32'h0,         0));
        vq.push_back(mk(0, 32'h0,         0, 0, 1, 1,   1, 4'd0,  0,  0,  0, 32'h0,         0));

        $display("[TB] reset state");
        doReset();
        checkResetValues("reset");

        $display("[TB] vector table, %0d cycles", vq.size());
        foreach (vq[i]) begin
            applyStimulus(vq[i]);
            @(negedge clk);
            checkOutput(vq[i], i);
            nextCyc();
        end

        // Output busy for 10 request cycles, then free.
        $display("[TB] busy output wait");
        doReset();
        bus.arb_busy  = 1'b1;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0000_0013, 1'b0);
        nextCyc();
        drive(1'b1, 32'h0000_0024, 1'b1);
        nextCyc();
        drive(1'b0, 32'h0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("busy%0d claim_req", c), 32'(bus.claim_req), 32'd0);
            check($sformatf("busy%0d out_valid", c), 32'(bus.out_valid), 32'd0);
            check($sformatf("busy%0d arb_addr", c), 32'(bus.arb_addr), 32'd3);
            nextCyc();
        end
        bus.arb_busy = 1'b0;
        @(negedge clk);
        check("busy_fall claim_req", 32'(bus.claim_req), 32'd1);
        check("busy_fall out_valid", 32'(bus.out_valid), 32'd0);
        nextCyc();
        @(negedge clk);
        check("busy hdr out_valid", 32'(bus.out_valid), 32'd1);
        check("busy hdr out_data", bus.out_data, 32'h0000_0013);
        nextCyc();
        @(negedge clk);
        check("busy tail out_data", bus.out_data, 32'h0000_0024);
        check("busy tail out_last", 32'(bus.out_last), 32'd1);
        nextCyc();
        @(negedge clk);
        check("busy release", 32'(bus.release_pulse), 32'd1);
        check("busy rel arb_addr", 32'(bus.arb_addr), 32'd3);
        nextCyc();

        // Overflow: 10 flits offered with the crossbar stalled, 8 must be kept.
        $display("[TB] FIFO full");
        doReset();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 32'h0000_1006 + 32'(i * 16), (i == 7));
            @(negedge clk);
            check($sformatf("full push%0d in_ready", i), 32'(bus.in_ready), (i < 8) ? 32'd1 : 32'd0);
            nextCyc();
        end
        drive(1'b0, 32'h0, 1'b0);
        bus.out_ready = 1'b1;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            check($sformatf("drain%0d out_valid", j), 32'(bus.out_valid), 32'd1);
            check($sformatf("drain%0d out_data", j), bus.out_data, 32'h0000_1006 + 32'(j * 16));
            check($sformatf("drain%0d out_last", j), 32'(bus.out_last), (j == 7) ? 32'd1 : 32'd0);
            nextCyc();
        end
        @(negedge clk);
        check("full release", 32'(bus.release_pulse), 32'd1);
        check("full rel arb_addr", 32'(bus.arb_addr), 32'd6);
        nextCyc();
        @(negedge clk);
        check("full after out_data", bus.out_data, 32'd0);
        check("full after in_ready", 32'(bus.in_ready), 32'd1);
        check("full after arb_addr", 32'(bus.arb_addr), 32'd0);
        nextCyc();
        @(negedge clk);
        check("full idle claim_req", 32'(bus.claim_req), 32'd0);
        nextCyc();

        // Reset asserted while a packet is being transferred.
        $display("[TB] reset mid-transfer");
        doReset();
        bus.out_ready = 1'b0;
        drive(1'b1, 32'h0000_0055, 1'b0);
        nextCyc();
        drive(1'b1, 32'h0000_0066, 1'b0);
        nextCyc();
        drive(1'b1, 32'h0000_0077, 1'b1);
        nextCyc();
        drive(1'b0, 32'h0, 1'b0);
        @(negedge clk);
        check("pre-rst out_valid", 32'(bus.out_valid), 32'd1);
        check("pre-rst arb_addr", 32'(bus.arb_addr), 32'd5);
        #1;
        rst = 1'b1;
        #1;
        checkResetValues("async rst");
        nextCyc();
        rst = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b1, 32'h0000_0079, 1'b1);
        nextCyc();
        drive(1'b0, 32'h0, 1'b0);
        nextCyc();
        @(negedge clk);
        check("fresh claim_req", 32'(bus.claim_req), 32'd1);
        check("fresh arb_addr", 32'(bus.arb_addr), 32'd9);
        nextCyc();
        @(negedge clk);
        check("fresh out_valid", 32'(bus.out_valid), 32'd1);
        check("fresh out_data", bus.out_data, 32'h0000_0079);
        nextCyc();
        @(negedge clk);
        check("fresh release", 32'(bus.release_pulse), 32'd1);
        check("fresh rel arb_addr", 32'(bus.arb_addr), 32'd9);
        nextCyc();
        @(negedge clk);
        check("fresh idle arb_addr", 32'(bus.arb_addr), 32'd0);
        nextCyc();

`ifdef INPUT_PORT_TIMEOUT_EN
        // Output stuck busy: 4 request cycles, then both flits are discarded.
        $display("[TB] timeout drop");
        doReset();
        bus.arb_busy  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            if (c == 0) drive(1'b1, 32'h0000_0052, 1'b0);
            else if (c == 1) drive(1'b1, 32'h0000_0063, 1'b1);
            else drive(1'b0, 32'h0, 1'b0);
            @(negedge clk);
            check($sformatf("to%0d drop", c), 32'(bus.drop), (c == 7) ? 32'd1 : 32'd0);
            check($sformatf("to%0d out_valid", c), 32'(bus.out_valid), 32'd0);
            check($sformatf("to%0d release", c), 32'(bus.release_pulse), 32'd0);
            check($sformatf("to%0d claim_req", c), 32'(bus.claim_req), 32'd0);
            if (c >= 2 && c <= 5) begin
                check($sformatf("to%0d arb_addr", c), 32'(bus.arb_addr), 32'd2);
            end
            nextCyc();
        end
        @(negedge clk);
        check("to empty out_data", bus.out_data, 32'd0);
        check("to empty in_ready", 32'(bus.in_ready), 32'd1);
        check("to idle arb_addr", 32'(bus.arb_addr), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
